// File: rtl/riscv_defines.sv
// Shared core definitions: word width, fetch FSM states and the prefetch entry layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_defines;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_e;

   // One prefetched instruction together with the address it was fetched from.
   typedef struct packed {
      logic [WORD_WIDTH-1:0] instr;
      logic [WORD_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer with push/pop/flush and an occupancy count.
// Latency: a pushed entry is visible on head the cycle after the push; no bypass.
// Backpressure: a push while full (without a same-cycle pop) is ignored; flush wins over push/pop.
// Ports: clk, rst (sync, active high), flush, push/push_data, pop, head, empty, count.
module fetch_fifo
   import riscv_defines::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = $bits(fetch_entry_t)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH so non-power-of-two depths work.
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory transaction feeding a small prefetch FIFO.
// Latency: response data reaches instr_o the cycle after instr_rvalid_i; first request the cycle after reset release.
// Backpressure: new requests are issued only while the FIFO can absorb the reply; decode stalls via instr_ready_i.
// Ports: clk_i/rst_i; memory side instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i;
//        decode side instr_o/pc_o/instr_valid_o/instr_ready_i; control side redirect_i/redirect_addr_i.
module fetch_unit
   import riscv_defines::*;
#(
   parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  instr_req_o,
   output logic [WORD_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [WORD_WIDTH-1:0] instr_rdata_i,
   output logic [WORD_WIDTH-1:0] instr_o,
   output logic [WORD_WIDTH-1:0] pc_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   input  logic                  redirect_i,
   input  logic [WORD_WIDTH-1:0] redirect_addr_i
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e          state;
   fetch_state_e          state_nxt;
   logic [WORD_WIDTH-1:0] fetch_addr;
   logic [WORD_WIDTH-1:0] fetch_addr_nxt;
   logic [WORD_WIDTH-1:0] held_target;
   logic [WORD_WIDTH-1:0] held_target_nxt;
   logic                  held_kill;
   logic                  held_kill_nxt;
   logic [CW-1:0]         count;
   logic [CW:0]           count_after_push;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [WORD_WIDTH-1:0] target;
   fetch_entry_t          push_entry;
   fetch_entry_t          head_entry;

   assign target           = {redirect_addr_i[WORD_WIDTH-1:2], 2'b00};
   assign pop              = !fifo_empty && instr_ready_i && !redirect_i;
   assign count_after_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

   // In WAIT the fetch address has already advanced past the granted word, and
   // any redirect that would have moved it also discards the reply, so the
   // granted address is always fetch_addr - 4 when a push happens.
   assign push_entry.instr = instr_rdata_i;
   assign push_entry.pc    = fetch_addr - WORD_WIDTH'(4);

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (redirect_i),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .empty     (fifo_empty),
      .count     (count)
   );

   assign instr_req_o   = (state == REQ);
   assign instr_addr_o  = fetch_addr;
   assign instr_valid_o = !fifo_empty;
   assign instr_o       = head_entry.instr;
   assign pc_o          = head_entry.pc;

   always_comb begin
      state_nxt       = state;
      fetch_addr_nxt  = fetch_addr;
      held_target_nxt = held_target;
      held_kill_nxt   = held_kill;
      push            = 1'b0;
      unique case (state)
         IDLE: begin
            // Nothing is outstanding here, so the issue test reduces to count < depth.
            if (redirect_i) begin
               fetch_addr_nxt = target;
               state_nxt      = REQ;
            end else if (count < CW'(FIFO_DEPTH)) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (instr_gnt_i) begin
               if (redirect_i || held_kill) begin
                  state_nxt      = DISCARD;
                  fetch_addr_nxt = redirect_i ? target : held_target;
                  held_kill_nxt  = 1'b0;
               end else begin
                  state_nxt      = WAIT;
                  fetch_addr_nxt = fetch_addr + WORD_WIDTH'(4);
               end
            end else if (redirect_i) begin
               // The ungranted request must stay on the bus unchanged; park the
               // target and apply it once the grant arrives.
               held_kill_nxt   = 1'b1;
               held_target_nxt = target;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               fetch_addr_nxt = target;
               state_nxt      = instr_rvalid_i ? REQ : DISCARD;
            end else if (instr_rvalid_i) begin
               push      = 1'b1;
               state_nxt = (count_after_push < (CW+1)'(FIFO_DEPTH)) ? REQ : IDLE;
            end
         end
         DISCARD: begin
            if (redirect_i) begin
               fetch_addr_nxt = target;
            end
            if (instr_rvalid_i) begin
               state_nxt = REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         fetch_addr  <= BOOT_ADDR;
         held_target <= '0;
         held_kill   <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_addr  <= fetch_addr_nxt;
         held_target <= held_target_nxt;
         held_kill   <= held_kill_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable grant/response delays plus a
// program-order model (next expected pc, word contents as a function of address).
// Ports: none.
module tb_fetch_unit;

   localparam logic [31:0] BOOT = 32'h0000_0080;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = 32'h0;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   // memory responder state and knobs
   int          gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
   int          gnt_wait = 0, rsp_wait = 0;
   bit          rsp_pend = 0, rsp_stale = 0;
   logic [31:0] rsp_addr = 32'h0;
   int          n_gnt = 0, n_pop = 0;

   // program-order model
   logic [31:0] exp_pc = BOOT;
   bit          prev_req_wait = 0, prev_redirect = 0;
   logic [31:0] prev_addr = 32'h0;

   fetch_unit u_dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .instr_o         (instr_o),
      .pc_o            (pc_o),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ ~a[15:0]};
   endfunction

   // One clock cycle: check outputs of the current cycle, drive memory side, advance.
   task automatic tick();
      bit          gnt_now, rv_now, req_b, rst_b, redir_b;
      logic [31:0] addr_b;
      if (!rst_i) begin
         if (prev_redirect) begin
            n_tests++;
            if (instr_valid_o !== 1'b0)
               $display("FAIL flush_after_redirect: instr_valid_o=%b required 0", instr_valid_o);
            if (instr_valid_o !== 1'b0) n_fail++;
         end
         if (prev_req_wait) begin
            n_tests++;
            if (instr_req_o !== 1'b1 || instr_addr_o !== prev_addr) begin
               n_fail++;
               $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h", instr_req_o, instr_addr_o, prev_addr);
            end
         end
         if (instr_valid_o === 1'b1) begin
            n_tests++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
               n_fail++;
               $display("FAIL head_order: pc=%h instr=%h required pc=%h instr=%h", pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
         end
         if (instr_req_o === 1'b1) begin
            n_tests++;
            if (instr_addr_o[1:0] !== 2'b00) begin
               n_fail++;
               $display("FAIL addr_align: addr=%h required low bits 00", instr_addr_o);
            end
         end
      end
      rv_now  = rsp_pend && (rsp_wait == 0);
      gnt_now = !rst_i && (instr_req_o === 1'b1) && (gnt_wait == 0);
      instr_rvalid_i = rv_now;
      instr_rdata_i  = rv_now ? (rsp_stale ? 32'hDEAD_BEEF : mem_word(rsp_addr)) : 32'h0;
      instr_gnt_i    = gnt_now;
      if (gnt_now) begin
         n_tests++;
         if (rsp_pend && !rv_now) begin
            n_fail++;
            $display("FAIL one_outstanding: grant at %h while %h still pending, required none pending", instr_addr_o, rsp_addr);
         end
      end
      if (!rst_i) begin
         if (redirect_i) exp_pc = {redirect_addr_i[31:2], 2'b00};
         else if (instr_valid_o === 1'b1 && instr_ready_i) begin
            exp_pc = exp_pc + 32'd4;
            n_pop++;
         end
      end
      req_b   = (instr_req_o === 1'b1);
      addr_b  = instr_addr_o;
      rst_b   = rst_i;
      redir_b = redirect_i;
      @(posedge clk_i);
      #1;
      prev_req_wait = !rst_b && req_b && !gnt_now;
      prev_addr     = addr_b;
      prev_redirect = !rst_b && redir_b;
      if (rv_now) rsp_pend = 0;
      else if (rsp_pend && rsp_wait > 0) rsp_wait--;
      if (gnt_now) begin
         rsp_pend  = 1;
         rsp_stale = 0;
         rsp_addr  = addr_b;
         rsp_wait  = int'($urandom_range(rv_max, rv_min));
         gnt_wait  = int'($urandom_range(gnt_max, gnt_min));
         n_gnt++;
      end else if (req_b && !rst_b && gnt_wait > 0) begin
         gnt_wait--;
      end
      if (rst_b) exp_pc = BOOT;
      redirect_i     = 1'b0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
   endtask

   task automatic set_delays(input int gmin, input int gmax, input int rmin, input int rmax);
      gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
   endtask

   // Leaves the bench at the first cycle after reset release (DUT should be requesting).
   task automatic do_reset();
      rst_i = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0; rsp_pend = 0;
      tick(); tick();
      rst_i = 1'b0;
      gnt_wait = int'($urandom_range(gnt_max, gnt_min));
      tick();
   endtask

   task automatic test_reset();
      set_delays(0, 0, 0, 0);
      rst_i = 1'b1; instr_ready_i = 1'b0; rsp_pend = 0;
      tick(); tick();
      n_tests++;
      if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b valid=%b required 0 0", instr_req_o, instr_valid_o);
      end
      n_tests++;
      if (instr_addr_o !== BOOT) begin
         n_fail++;
         $display("FAIL reset_addr: addr=%h required %h", instr_addr_o, BOOT);
      end
      rst_i = 1'b0;
      gnt_wait = 5;
      tick();
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h required 1 %h", instr_req_o, instr_addr_o, BOOT);
      end
   endtask

   task automatic test_basic();
      set_delays(0, 0, 0, 0);
      do_reset();
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
         n_fail++;
         $display("FAIL basic_req0: req=%b addr=%h required 1 00000080", instr_req_o, instr_addr_o);
      end
      tick();
      n_tests++;
      if (instr_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_no_bypass: valid=%b required 0", instr_valid_o);
      end
      tick();
      n_tests++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h80) begin
         n_fail++;
         $display("FAIL basic_valid: valid=%b pc=%h required 1 00000080", instr_valid_o, pc_o);
      end
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h84) begin
         n_fail++;
         $display("FAIL basic_req1: req=%b addr=%h required 1 00000084", instr_req_o, instr_addr_o);
      end
   endtask

   task automatic test_backpressure();
      int g0, k;
      set_delays(0, 0, 0, 0);
      do_reset();
      g0 = n_gnt;
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (n_gnt - g0 != 2 || instr_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_stall: grants=%0d req=%b required 2 0", n_gnt - g0, instr_req_o);
      end
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i = 1'b0;
      k = 0;
      while (instr_req_o !== 1'b1 && k < 6) begin tick(); k++; end
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h88) begin
         n_fail++;
         $display("FAIL refill_req: req=%b addr=%h required 1 00000088", instr_req_o, instr_addr_o);
      end
   endtask

   task automatic test_redirect_wait();
      int k;
      bit saw_valid;
      set_delays(0, 0, 2, 2);
      do_reset();
      instr_ready_i = 1'b1;
      tick();
      redirect_i = 1'b1; redirect_addr_i = 32'h203;
      tick();
      k = 0; saw_valid = 0;
      while (instr_req_o !== 1'b1 && k < 10) begin
         if (instr_valid_o === 1'b1) saw_valid = 1;
         tick(); k++;
      end
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200 || saw_valid) begin
         n_fail++;
         $display("FAIL redirect_wait_req: req=%b addr=%h early_valid=%0d required 1 00000200 0", instr_req_o, instr_addr_o, saw_valid);
      end
      k = 0;
      while (instr_valid_o !== 1'b1 && k < 10) begin tick(); k++; end
      n_tests++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h200) begin
         n_fail++;
         $display("FAIL redirect_wait_data: valid=%b pc=%h required 1 00000200", instr_valid_o, pc_o);
      end
   endtask

   task automatic test_redirect_req();
      int g0, k;
      bit saw_valid;
      set_delays(3, 3, 0, 0);
      do_reset();
      instr_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_addr_i = 32'h300;
      tick();
      g0 = n_gnt; k = 0;
      while (n_gnt == g0 && k < 10) begin
         n_tests++;
         if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            n_fail++;
            $display("FAIL redirect_req_hold: req=%b addr=%h required 1 00000080", instr_req_o, instr_addr_o);
         end
         tick(); k++;
      end
      n_tests++;
      if (n_gnt == g0) begin
         n_fail++;
         $display("FAIL redirect_req_grant: grants=0 required 1 within 10 cycles");
      end
      k = 0; saw_valid = 0;
      while (instr_req_o !== 1'b1 && k < 10) begin
         if (instr_valid_o === 1'b1) saw_valid = 1;
         tick(); k++;
      end
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300 || saw_valid) begin
         n_fail++;
         $display("FAIL redirect_req_target: req=%b addr=%h early_valid=%0d required 1 00000300 0", instr_req_o, instr_addr_o, saw_valid);
      end
      k = 0;
      while (instr_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
      n_tests++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h300) begin
         n_fail++;
         $display("FAIL redirect_req_data: valid=%b pc=%h required 1 00000300", instr_valid_o, pc_o);
      end
   endtask

   task automatic test_redirect_pop_rvalid();
      int k;
      set_delays(0, 0, 0, 0);
      do_reset();
      tick(); tick(); tick();
      n_tests++;
      if (instr_valid_o !== 1'b1 || instr_req_o !== 1'b0 || !rsp_pend || rsp_wait != 0) begin
         n_fail++;
         $display("FAIL collide_setup: valid=%b req=%b required 1 0 with reply due", instr_valid_o, instr_req_o);
      end
      instr_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_addr_i = 32'h400;
      tick();
      n_tests++;
      if (instr_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_empty: valid=%b required 0", instr_valid_o);
      end
      k = 0;
      while (instr_valid_o !== 1'b1 && k < 10) begin tick(); k++; end
      n_tests++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h400) begin
         n_fail++;
         $display("FAIL collide_first: valid=%b pc=%h required 1 00000400", instr_valid_o, pc_o);
      end
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_reset_mid();
      int k;
      set_delays(0, 0, 3, 3);
      do_reset();
      instr_ready_i = 1'b1;
      tick();
      rst_i = 1'b1; rsp_stale = 1;
      tick();
      rst_i = 1'b0;
      gnt_wait = 2;
      tick();
      k = 0;
      while (instr_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
      n_tests++;
      if (instr_valid_o !== 1'b1 || pc_o !== BOOT || instr_o !== mem_word(BOOT)) begin
         n_fail++;
         $display("FAIL reset_mid_first: valid=%b pc=%h instr=%h required 1 %h %h", instr_valid_o, pc_o, instr_o, BOOT, mem_word(BOOT));
      end
   endtask

   task automatic test_random();
      int p0;
      set_delays(0, 3, 0, 3);
      do_reset();
      p0 = n_pop;
      for (int i = 0; i < 4000; i++) begin
         instr_ready_i = ($urandom_range(3, 0) != 0);
         if ($urandom_range(99, 0) < 4) begin
            redirect_i = 1'b1;
            redirect_addr_i = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
         end
         tick();
      end
      n_tests++;
      if (n_pop - p0 < 300) begin
         n_fail++;
         $display("FAIL random_progress: consumed=%0d required at least 300", n_pop - p0);
      end
   endtask

   initial begin
      @(posedge clk_i);
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_req();
      test_redirect_pop_rvalid();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
